// File: rtl/k054539_host_master.sv
// Host-side bus initiator for the 054539 CPU port.
// Turns single-word requests into timed NCS/NRD/NWR/AB/DB cycles.
//
// Ports:
//   CLK, RES                    clock, synchronous active-high reset
//   REQ, REQ_WR, REQ_ADDR,      request handshake; sampled only while idle
//   REQ_WDATA
//   BUSY, DONE, RDATA, TIMEOUT  status and read data back to the host
//   PIN_AB, PIN_AB09            address to the chip
//   PIN_DB_OUT, PIN_DB_OE,      data bus to/from the chip
//   PIN_DB_IN
//   NCS, NRD, NWR               active-low select and strobes
//   PIN_WAIT                    chip wait, high stretches the strobe
module k054539_host_master #(
    parameter int T_AS     = 1,
    parameter int T_CS     = 1,
    parameter int T_PW     = 8,
    parameter int T_HOLD   = 1,
    parameter int T_REC    = 2,
    parameter int WAIT_MAX = 64
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       REQ,
    input  logic       REQ_WR,
    input  logic [9:0] REQ_ADDR,
    input  logic [7:0] REQ_WDATA,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RDATA,
    output logic       TIMEOUT,
    output logic [7:0] PIN_AB,
    output logic       PIN_AB09,
    output logic [7:0] PIN_DB_OUT,
    output logic       PIN_DB_OE,
    input  logic [7:0] PIN_DB_IN,
    output logic       NCS,
    output logic       NRD,
    output logic       NWR,
    input  logic       PIN_WAIT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CSLO,
        S_STROBE,
        S_WAITX,
        S_HOLD,
        S_RECOV
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic       wr_q;

    logic       accept;
    logic       capture;
    logic       abort;

    logic       busy_d;
    logic       done_d;
    logic       ncs_d;
    logic       nrd_d;
    logic       nwr_d;
    logic       oe_d;
    logic       wr_nx;
    logic       strobe_on;

    // Address bit 8 has no pin on the chip side.
    logic       unused_addr8;
    assign unused_addr8 = REQ_ADDR[8];

    // Counter holds (remaining cycles - 1) of the current state.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (REQ) begin
                    state_nx = S_SETUP;
                    cnt_nx   = 8'(T_AS - 1);
                    accept   = 1'b1;
                end
            end
            S_SETUP: begin
                if (cnt == 8'd0) begin
                    state_nx = S_CSLO;
                    cnt_nx   = 8'(T_CS - 1);
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_CSLO: begin
                if (cnt == 8'd0) begin
                    state_nx = S_STROBE;
                    cnt_nx   = 8'(T_PW - 1);
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_STROBE: begin
                if (cnt != 8'd0) begin
                    cnt_nx = cnt - 8'd1;
                end else if (PIN_WAIT) begin
                    state_nx = S_WAITX;
                    cnt_nx   = 8'(WAIT_MAX - 1);
                end else begin
                    state_nx = S_HOLD;
                    cnt_nx   = 8'(T_HOLD - 1);
                    capture  = 1'b1;
                end
            end
            S_WAITX: begin
                if (!PIN_WAIT) begin
                    state_nx = S_HOLD;
                    cnt_nx   = 8'(T_HOLD - 1);
                    capture  = 1'b1;
                end else if (cnt == 8'd0) begin
                    state_nx = S_HOLD;
                    cnt_nx   = 8'(T_HOLD - 1);
                    abort    = 1'b1;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt == 8'd0) begin
                    state_nx = S_RECOV;
                    cnt_nx   = 8'(T_REC - 1);
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_RECOV: begin
                if (cnt == 8'd0) begin
                    state_nx = S_IDLE;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    // Pin levels are derived from the state being entered so that
    // the registered outputs line up with that state.
    always_comb begin
        wr_nx     = accept ? REQ_WR : wr_q;
        strobe_on = (state_nx == S_STROBE) || (state_nx == S_WAITX);
        busy_d    = (state_nx != S_IDLE);
        ncs_d     = !((state_nx == S_CSLO) || strobe_on ||
                      (state_nx == S_HOLD));
        nrd_d     = !(strobe_on && !wr_nx);
        nwr_d     = !(strobe_on && wr_nx);
        oe_d      = wr_nx && busy_d && (state_nx != S_RECOV);
        done_d    = (state_nx == S_HOLD) && (state != S_HOLD);
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            wr_q       <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            RDATA      <= 8'd0;
            TIMEOUT    <= 1'b0;
            PIN_AB     <= 8'd0;
            PIN_AB09   <= 1'b0;
            PIN_DB_OUT <= 8'd0;
            PIN_DB_OE  <= 1'b0;
            NCS        <= 1'b1;
            NRD        <= 1'b1;
            NWR        <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            BUSY      <= busy_d;
            DONE      <= done_d;
            PIN_DB_OE <= oe_d;
            NCS       <= ncs_d;
            NRD       <= nrd_d;
            NWR       <= nwr_d;
            if (accept) begin
                wr_q     <= REQ_WR;
                PIN_AB   <= REQ_ADDR[7:0];
                PIN_AB09 <= REQ_ADDR[9];
                TIMEOUT  <= 1'b0;
                if (REQ_WR) begin
                    PIN_DB_OUT <= REQ_WDATA;
                end
            end
            if (capture && !wr_q) begin
                RDATA <= PIN_DB_IN;
            end
            if (abort) begin
                TIMEOUT <= 1'b1;
                if (!wr_q) begin
                    RDATA <= 8'hFF;
                end
            end
        end
    end

endmodule

// File: tb/tb_k054539_host_master.sv
// Self-checking bench for k054539_host_master.
// Timeline model plus directed accesses with literal expectations.
module tb_k054539_host_master;

    localparam int A  = 1;
    localparam int C  = 1;
    localparam int P  = 8;
    localparam int H  = 1;
    localparam int R  = 2;
    localparam int WM = 4;

    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic       REQ = 1'b0;
    logic       REQ_WR = 1'b0;
    logic [9:0] REQ_ADDR = '0;
    logic [7:0] REQ_WDATA = '0;
    logic [7:0] PIN_DB_IN = '0;
    logic       PIN_WAIT = 1'b0;

    logic       BUSY;
    logic       DONE;
    logic [7:0] RDATA;
    logic       TIMEOUT;
    logic [7:0] PIN_AB;
    logic       PIN_AB09;
    logic [7:0] PIN_DB_OUT;
    logic       PIN_DB_OE;
    logic       NCS;
    logic       NRD;
    logic       NWR;

    k054539_host_master #(
        .T_AS(A), .T_CS(C), .T_PW(P),
        .T_HOLD(H), .T_REC(R), .WAIT_MAX(WM)
    ) dut (
        .CLK(CLK), .RES(RES),
        .REQ(REQ), .REQ_WR(REQ_WR),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .BUSY(BUSY), .DONE(DONE),
        .RDATA(RDATA), .TIMEOUT(TIMEOUT),
        .PIN_AB(PIN_AB), .PIN_AB09(PIN_AB09),
        .PIN_DB_OUT(PIN_DB_OUT), .PIN_DB_OE(PIN_DB_OE),
        .PIN_DB_IN(PIN_DB_IN),
        .NCS(NCS), .NRD(NRD), .NWR(NWR),
        .PIN_WAIT(PIN_WAIT)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Scenario knobs handed to the model by the driver.
    int sc_extra = 0;
    bit sc_abort = 0;

    // Model: each access is a fixed timeline of cycle numbers
    // n = 1 .. A+C+P+X+H+R, followed by one idle cycle.
    bit         m_ok = 0;
    bit         m_active = 0;
    int         m_n = 0;
    bit         m_wr = 0;
    int         m_x = 0;
    bit         m_abort = 0;
    logic [7:0] m_rdata = 0;
    logic       m_to = 0;
    logic [7:0] m_ab = 0;
    logic       m_ab09 = 0;
    logic [7:0] m_dbout = 0;

    always @(posedge CLK) begin
        if (RES) begin
            m_ok     = 1;
            m_active = 0;
            m_n      = 0;
            m_rdata  = 0;
            m_to     = 0;
            m_ab     = 0;
            m_ab09   = 0;
            m_dbout  = 0;
        end else if (!m_active) begin
            if (REQ) begin
                m_active = 1;
                m_n      = 1;
                m_wr     = REQ_WR;
                m_ab     = REQ_ADDR[7:0];
                m_ab09   = REQ_ADDR[9];
                if (REQ_WR) m_dbout = REQ_WDATA;
                m_to     = 0;
                m_abort  = sc_abort;
                m_x      = sc_abort ? WM : sc_extra;
            end
        end else begin
            m_n++;
            if (m_n == A + C + P + m_x + 1) begin
                if (m_abort) begin
                    m_to = 1;
                    if (!m_wr) m_rdata = 8'hFF;
                end else if (!m_wr) begin
                    m_rdata = PIN_DB_IN;
                end
            end
            if (m_n > A + C + P + m_x + H + R) m_active = 0;
        end
    end

    always @(negedge CLK) begin
        if (m_ok) begin
            int  se;
            int  he;
            bit  stb;
            se  = A + C + P + m_x;
            he  = se + H;
            stb = m_active && m_n > A + C && m_n <= se;
            chk("busy", BUSY, m_active);
            chk("done", DONE, m_active && m_n == se + 1);
            chk("ncs", NCS,
                !(m_active && m_n > A && m_n <= he));
            chk("nrd", NRD, !(stb && !m_wr));
            chk("nwr", NWR, !(stb && m_wr));
            chk("db_oe", PIN_DB_OE,
                m_active && m_wr && m_n <= he);
            chk("db_out", PIN_DB_OUT, m_dbout);
            chk("ab", PIN_AB, m_ab);
            chk("ab09", PIN_AB09, m_ab09);
            chk("rdata", RDATA, m_rdata);
            chk("timeout", TIMEOUT, m_to);
        end
    end

    // One access from a negedge to the negedge of its idle cycle
    // (or one cycle after a reset pulse).
    task automatic access(input bit wr,
                          input logic [9:0] addr,
                          input logic [7:0] wdata,
                          input logic [7:0] dbin,
                          input int extra,
                          input bit abrt,
                          input int rst_at,
                          input bit keep,
                          input bit glitch,
                          output int stb_len,
                          output int done_n,
                          output int idle_n);
        int total;
        int wend;
        stb_len   = 0;
        done_n    = 0;
        idle_n    = 0;
        REQ       = 1'b1;
        REQ_WR    = wr;
        REQ_ADDR  = addr;
        REQ_WDATA = wdata;
        PIN_DB_IN = dbin;
        PIN_WAIT  = 1'b0;
        sc_extra  = extra;
        sc_abort  = abrt;
        total = A + C + P + (abrt ? WM : extra) + H + R;
        if (abrt) wend = A + C + P + WM;
        else if (extra > 0) wend = A + C + P + extra - 1;
        else wend = 0;
        @(posedge CLK);
        @(negedge CLK);
        if (!keep) REQ = 1'b0;
        for (int n = 1; n <= total + 1; n++) begin
            if (NRD == 1'b0 || NWR == 1'b0) stb_len++;
            if (DONE) done_n = n;
            if (!BUSY && idle_n == 0) idle_n = n;
            if (rst_at != 0 && n == rst_at + 1) begin
                RES = 1'b0;
                break;
            end
            PIN_WAIT = (n > A + C && n <= wend);
            if (glitch) REQ = (n == 5);
            if (n == rst_at) RES = 1'b1;
            if (n == total + 1) break;
            @(posedge CLK);
            @(negedge CLK);
        end
        PIN_WAIT = 1'b0;
    endtask

    int sl;
    int dn;
    int idn;

    initial begin
        repeat (3) @(negedge CLK);
        RES = 1'b0;
        chk("rst_ncs", NCS, 1'b1);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_rdata", RDATA, 8'h00);
        @(negedge CLK);

        access(1, 10'h050, 8'h11, 8'h00, 0, 0, 0, 0, 0, sl, dn, idn);
        chk("w050_stb", sl, 8);
        chk("w050_done", dn, 11);
        chk("w050_idle", idn, 14);
        chk("w050_ab", PIN_AB, 8'h50);

        access(1, 10'h210, 8'h55, 8'h00, 0, 0, 0, 0, 0, sl, dn, idn);
        chk("w210_ab", PIN_AB, 8'h10);
        chk("w210_ab09", PIN_AB09, 1'b1);
        chk("w210_db", PIN_DB_OUT, 8'h55);

        access(0, 10'h051, 8'h00, 8'hA5, 0, 0, 0, 0, 0, sl, dn, idn);
        chk("r051_stb", sl, 8);
        chk("r051_done", dn, 11);
        chk("r051_rdata", RDATA, 8'hA5);

        access(0, 10'h052, 8'h00, 8'h3C, 4, 0, 0, 0, 0, sl, dn, idn);
        chk("rwait_stb", sl, 12);
        chk("rwait_done", dn, 15);
        chk("rwait_to", TIMEOUT, 1'b0);
        chk("rwait_rdata", RDATA, 8'h3C);

        access(0, 10'h053, 8'h00, 8'h77, 0, 1, 0, 0, 0, sl, dn, idn);
        chk("abort_stb", sl, 12);
        chk("abort_to", TIMEOUT, 1'b1);
        chk("abort_rdata", RDATA, 8'hFF);

        access(1, 10'h001, 8'h9A, 8'h00, 0, 0, 0, 0, 0, sl, dn, idn);
        chk("clr_to", TIMEOUT, 1'b0);

        access(1, 10'h0AA, 8'hC3, 8'h00, 0, 0, 5, 0, 0, sl, dn, idn);
        chk("rst_nodone", dn, 0);
        chk("rst_ncs2", NCS, 1'b1);
        chk("rst_oe", PIN_DB_OE, 1'b0);

        access(0, 10'h3FF, 8'h00, 8'h5A, 0, 0, 0, 0, 1, sl, dn, idn);
        chk("glitch_done", dn, 11);

        access(1, 10'h011, 8'h22, 8'h00, 0, 0, 0, 1, 0, sl, dn, idn);
        access(0, 10'h012, 8'h00, 8'h44, 0, 0, 0, 0, 0, sl, dn, idn);
        chk("b2b_done", dn, 11);
        chk("b2b_rdata", RDATA, 8'h44);

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
